// File: rtl/regdump_pkg.sv
// Shared types for the regfile dump sequencer: FSM state encoding, counter and beat widths.
// Delta suppression is enabled by defining REGDUMP_DELTA_EN (see regfile_dump_sequencer).
package regdump_pkg;

  localparam int DUMP_CNT_W = 16;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } state_e;

  // Beat payload is {addr, data, last}.
  function automatic int beat_width(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/regdump_shadow.sv
// Last-emitted value per register with valid bits; write on handshake, compare during capture.
// Compare is combinational on the read address; reset only clears the valid bits.
module regdump_shadow
  import regdump_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [DW-1:0] cmp_data_i,
  output logic          hit_o
);

  logic [DW-1:0]    mem_q [NREGS];
  logic [NREGS-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        vld_q <= '0;
    else if (wr_en_i) vld_q[wr_addr_i] <= 1'b1;
  end

  assign hit_o = vld_q[rd_addr_i] && (mem_q[rd_addr_i] == cmp_data_i);

endmodule

// File: rtl/regfile_dump_sequencer.sv
// Walks the regfile debug port on request, one {addr,data,last} beat per register (>=3 cycles/beat,
// payload held under backpressure). Define REGDUMP_DELTA_EN to suppress beats unchanged since last emitted.
module regfile_dump_sequencer
  import regdump_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int SKIP_ZERO = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dump_req_i,
  output logic                  rf_re_o,
  output logic [AW-1:0]         rf_raddr_o,
  input  logic [DW-1:0]         rf_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [AW-1:0]         out_addr_o,
  output logic [DW-1:0]         out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic [DUMP_CNT_W-1:0] dump_cnt_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam logic [AW-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          idx_q;
  logic                   pend_q;
  logic [AW-1:0]          out_addr_q;
  logic [DW-1:0]          out_data_q;
  logic                   out_last_q;
  logic [DUMP_CNT_W-1:0]  dump_cnt_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;
  logic                   start, is_last, hs, skip_beat;

  assign start   = (state_q == ST_IDLE) && (dump_req_i || pend_q);
  assign is_last = (idx_q == LAST_IDX);
  assign hs      = (state_q == ST_SEND) && out_ready_i;

`ifdef REGDUMP_DELTA_EN
  logic shadow_hit;

  regdump_shadow #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_shadow (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (hs),
    .wr_addr_i  (out_addr_q),
    .wr_data_i  (out_data_q),
    .rd_addr_i  (idx_q),
    .cmp_data_i (rf_rdata_i),
    .hit_o      (shadow_hit)
  );

  // The final index always emits so every snapshot is terminated by a last beat.
  assign skip_beat = shadow_hit && !is_last;
`else
  assign skip_beat = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (dump_req_i || pend_q) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = skip_beat ? ST_ISSUE : ST_SEND;
      ST_SEND:    if (out_ready_i) state_d = out_last_q ? ST_IDLE : ST_ISSUE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_re_o     = 1'b0;
    rf_raddr_o  = '0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      ST_IDLE:  busy_o = 1'b0;
      ST_ISSUE: begin
        rf_re_o    = 1'b1;
        rf_raddr_o = idx_q;
      end
      ST_SEND:  out_valid_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      pend_q     <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      dump_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (start) begin
        idx_q  <= FIRST_IDX;
        pend_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && dump_req_i) begin
        // One request queues behind the active snapshot; further ones are counted and dropped.
        if (!pend_q)                 pend_q     <= 1'b1;
        else if (drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 8'd1;
      end
      if (state_q == ST_CAPTURE) begin
        if (skip_beat) begin
          idx_q <= idx_q + AW'(1);
        end else begin
          out_addr_q <= idx_q;
          out_data_q <= rf_rdata_i;
          out_last_q <= is_last;
        end
      end
      if (hs) begin
        if (out_last_q) dump_cnt_q <= dump_cnt_q + 16'd1;
        else            idx_q      <= idx_q + AW'(1);
      end
    end
  end

  assign out_addr_o = out_addr_q;
  assign out_data_o = out_data_q;
  assign out_last_o = out_last_q;
  assign dump_cnt_o = dump_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
